level_to_pulse_fsm: RTL and testbench

//   Rising-edge detector built as a synchronous Moore FSM.

---
 rtl/level_to_pulse_fsm_if.sv | 18 +
 rtl/level_to_pulse_fsm.sv | 104 ++++++++++
 tb/tb_level_to_pulse_fsm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/level_to_pulse_fsm_if.sv
// Level-to-pulse interface: carries the level input and the pulse output.
//   X             : level input, synchronous to clk unless the synchronizer is built in
//   output_signal : registered pulse output
// master drives X and observes the pulse; slave is the FSM side.
interface level_to_pulse_fsm_if;
  logic X;
  logic output_signal;

  modport master (
    output X,
    input  output_signal
  );

  modport slave (
    input  X,
    output output_signal
  );
endinterface

// File: rtl/level_to_pulse_fsm.sv
// Rising-edge detector built as a Moore FSM: each 0->1 transition of the level
// input produces one output pulse PULSE_CYCLES clocks wide (legal 1..255).
// A level held high triggers once; X must be sampled low before re-arming.
// Ports:
//   clk    : system clock, all state changes on its rising edge
//   reset  : synchronous, active-high reset
//   bus    : level_to_pulse_fsm_if.slave (X in, output_signal out)
// Optional build macro LVL2PULSE_SYNC_EN: routes X through a 2-flop
// synchronizer (reset to 0) ahead of the FSM, adding 2 cycles of latency.
module level_to_pulse_fsm #(
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  level_to_pulse_fsm_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             pulse_q;
  logic             x_s;

`ifdef LVL2PULSE_SYNC_EN
  logic x_meta;
  logic x_sync;

  // Two-flop synchronizer for an asynchronous level input
  always_ff @(posedge clk) begin
    if (reset) begin
      x_meta <= 1'b0;
      x_sync <= 1'b0;
    end else begin
      x_meta <= bus.X;
      x_sync <= x_meta;
    end
  end

  assign x_s = x_sync;
`else
  assign x_s = bus.X;
`endif

  // State, pulse counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      // Output flop mirrors the PULSE state it is entering, so it is high
      // exactly while state==PULSE
      pulse_q <= (state_next == PULSE);
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (x_s) begin
          state_next = PULSE;
          count_next = CNT_W'(1);
        end
      end
      PULSE: begin
        // Pulse width is fixed; X is ignored until the last pulse cycle
        if (count < PULSE_LAST) begin
          count_next = count + CNT_W'(1);
        end else begin
          count_next = '0;
          state_next = x_s ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!x_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign bus.output_signal = pulse_q;

endmodule

// File: tb/tb_level_to_pulse_fsm.sv
// Scoreboard bench: two instances (PULSE_CYCLES=1 and 3) share X and reset.
// Each cycle the stimulus is driven, a behavioural model pushes the expected
// output for the coming edge, and after the edge the result is popped and checked.
module tb_level_to_pulse_fsm;

  logic clk;
  logic reset;

  level_to_pulse_fsm_if bus1 ();
  level_to_pulse_fsm_if bus3 ();

  level_to_pulse_fsm #(.PULSE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  level_to_pulse_fsm #(.PULSE_CYCLES(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  logic exp_q1[$];
  logic exp_q3[$];

  // Model state: remaining pulse cycles and whether a rising level may trigger
  int rem1   = 0;
  int rem3   = 0;
  bit armed1 = 1'b1;
  bit armed3 = 1'b1;
  logic xd1  = 1'b0;
  logic xd2  = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected output after the next edge, given the value the FSM will sample
  task automatic model_step(input int p, input logic x, input logic rst,
                            inout int rem, inout bit armed, output logic exp);
    if (rst) begin
      rem   = 0;
      armed = 1'b1;
      exp   = 1'b0;
    end else if (rem > 0) begin
      rem--;
      exp = (rem > 0);
      if (rem == 0) armed = !x;
    end else if (armed && x) begin
      rem   = p;
      armed = 1'b0;
      exp   = 1'b1;
    end else begin
      if (!x) armed = 1'b1;
      exp = 1'b0;
    end
  endtask

  task automatic step(input logic x, input logic rst);
    logic e1;
    logic e3;
    logic xe;
    logic o1;
    logic o3;
    @(negedge clk);
    bus1.X = x;
    bus3.X = x;
    reset  = rst;
`ifdef LVL2PULSE_SYNC_EN
    xe = rst ? 1'b0 : xd2;
    if (rst) begin
      xd2 = 1'b0;
      xd1 = 1'b0;
    end else begin
      xd2 = xd1;
      xd1 = x;
    end
`else
    xe = x;
`endif
    model_step(1, xe, rst, rem1, armed1, e1);
    model_step(3, xe, rst, rem3, armed3, e3);
    exp_q1.push_back(e1);
    exp_q3.push_back(e3);
    @(posedge clk);
    #1;
    step_no++;
    o1 = bus1.output_signal;
    o3 = bus3.output_signal;
    if (exp_q1.size() == 0 || exp_q3.size() == 0) begin
      check($sformatf("scoreboard_empty_%0d", step_no), 1'b1, 1'b0);
    end else begin
      check($sformatf("p1_step%0d", step_no), o1, exp_q1.pop_front());
      check($sformatf("p3_step%0d", step_no), o3, exp_q3.pop_front());
    end
  endtask

  task automatic run_seq(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    bus1.X = 1'b0;
    bus3.X = 1'b0;

    // Reset with X low, then idle after release
    step(1'b0, 1'b1);
    run_seq(16'b000, 3);

    // Level held high for 4 cycles: one pulse
    run_seq(16'b00_1111_000, 9);

    // Two rising edges within a burst
    run_seq(16'b1111_0110_0000, 12);

    // X high through reset and release: pulse on first edge after reset
    step(1'b1, 1'b1);
    run_seq(16'b11110000, 8);

    // Single-cycle high yields a full-width pulse
    run_seq(16'b1_000000, 7);

    // X drops and rises during a wide pulse, then held: no re-trigger
    run_seq(16'b1011_1100_0000, 12);

    // Reset on the second cycle of a wide pulse
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    run_seq(16'b00000, 5);

    // Random tail
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
